// File: rtl/uart_pkg.sv
// Shared register offsets, STATUS bit positions and serializer state encoding
// for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_BAUD   = 4'h8;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. Push when full and pop when empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV registers, TX FIFO
// and serializer. Define MMIO_UART_TX_PARITY_EN for an even-parity bit (11-bit frame).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [2:0]  mem_len,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  import uart_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    reg_off;
  logic          wr_tx, wr_stat, wr_baud;
  logic [15:0]   baud_div;
  logic          overflow;
  logic [31:0]   status_word;
  logic [3:0]    fill_sat;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          unused_bus;

  tx_state_e     state, state_nx;
  logic [15:0]   period, bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done, busy, tx_d, tx_q;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign unused_bus = ^{mem_len, mem_read, addr[1:0], data_in[31:16]};

  assign reg_off = {addr[3:2], 2'b00};
  assign sel     = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
  assign wr_tx   = mem_write && sel && (reg_off == REG_TXDATA);
  assign wr_stat = mem_write && sel && (reg_off == REG_STATUS);
  assign wr_baud = mem_write && sel && (reg_off == REG_BAUD);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .din   (data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow keys off the pre-edge full flag, so a same-cycle pop does not rescue the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div <= BAUD_DIV_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= data_in[15:0];
      if (wr_tx && fifo_full) overflow <= 1'b1;
      else if (wr_stat)       overflow <= 1'b0;
    end
  end

  assign fill_sat = (fifo_count >= CW'(15)) ? 4'hF : 4'(fifo_count);

  always_comb begin
    status_word                        = '0;
    status_word[STAT_FULL]             = fifo_full;
    status_word[STAT_EMPTY]            = fifo_empty;
    status_word[STAT_BUSY]             = busy;
    status_word[STAT_OVF]              = overflow;
    status_word[STAT_CNT_LSB +: 4]     = fill_sat;
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      unique case (reg_off)
        REG_STATUS: data_out = status_word;
        REG_BAUD:   data_out = {16'h0000, baud_div};
        default:    ;
      endcase
    end
  end

  assign bit_done = (bit_timer == period - 16'd1);
  assign busy     = (state != ST_IDLE);
  assign irq      = fifo_empty && !busy;
  assign tx       = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (!fifo_empty) state_nx = ST_START;
      ST_START:  if (bit_done) state_nx = ST_DATA;
`ifdef MMIO_UART_TX_PARITY_EN
      ST_DATA:   if (bit_done && bit_idx == 3'd7) state_nx = ST_PARITY;
      ST_PARITY: if (bit_done) state_nx = ST_STOP;
`else
      ST_DATA:   if (bit_done && bit_idx == 3'd7) state_nx = ST_STOP;
`endif
      ST_STOP:   if (bit_done) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    unique case (state)
      ST_IDLE:   fifo_pop = !fifo_empty;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg[0];
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_bit;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // tx is registered from the state, so the line trails the FSM by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= 1'b1;
      period    <= 16'd1;
      bit_timer <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (fifo_pop) begin
        shreg     <= fifo_dout;
        period    <= (baud_div == 16'd0) ? 16'd1 : baud_div;
        bit_timer <= '0;
        bit_idx   <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
        parity_bit <= ^fifo_dout;
`endif
      end else if (busy) begin
        if (bit_done) begin
          bit_timer <= '0;
          if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          bit_timer <= bit_timer + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx; parity frame checked only
// when MMIO_UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [2:0]  mem_len = 3'd2;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_out;
  logic        sel, tx, irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int w_cyc = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (16),
    .BAUD_DIV_RST (16'd434)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .data_in   (data_in),
    .mem_len   (mem_len),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_out  (data_out),
    .sel       (sel),
    .tx        (tx),
    .irq       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data_in = d; mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0; addr = '0; data_in = '0;
    w_cyc = cyc;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clk);
    addr = a; mem_read = 1'b1;
    #1;
    d = data_out; s = sel;
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic s;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", tx); end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL reset_irq got %b want 1", irq); end
    bus_read(BASE + 32'd4, d, s);
    vectors++;
    if (d !== 32'h0000_0002 || s !== 1'b1) begin
      miscompares++; $display("FAIL reset_status got %h sel %b want 00000002 sel 1", d, s);
    end
    bus_read(BASE + 32'd8, d, s);
    vectors++;
    if (d !== 32'd434) begin miscompares++; $display("FAIL reset_baud got %0d want 434", d); end
    bus_read(BASE + 32'd9, d, s);
    vectors++;
    if (d !== 32'd434) begin miscompares++; $display("FAIL baud_low_addr_bits got %0d want 434", d); end
    bus_read(BASE, d, s);
    vectors++;
    if (d !== 32'h0 || s !== 1'b1) begin
      miscompares++; $display("FAIL txdata_read got %h sel %b want 0 sel 1", d, s);
    end
    bus_read(BASE + 32'd12, d, s);
    vectors++;
    if (d !== 32'h0 || s !== 1'b0) begin
      miscompares++; $display("FAIL hole_decode got %h sel %b want 0 sel 0", d, s);
    end
    bus_read(BASE + 32'd16, d, s);
    vectors++;
    if (d !== 32'h0 || s !== 1'b0) begin
      miscompares++; $display("FAIL out_of_range got %h sel %b want 0 sel 0", d, s);
    end
  endtask

  task automatic test_frame_a5();
    logic [31:0] d;
    logic s;
    logic [9:0] frame;
    logic exp_irq;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(BASE + 32'd8, 32'hFFFF_0004);
    bus_read(BASE + 32'd8, d, s);
    vectors++;
    if (d !== 32'h0000_0004) begin miscompares++; $display("FAIL baud_write got %h want 00000004", d); end
    bus_write(BASE, 32'h0000_00A5);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL a5_irq_fall got %b want 0", irq); end
    @(posedge clk); #1;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL a5_tx_edge1 got %b want 1", tx); end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        exp_irq = (b == 9 && c == 3);
        vectors++;
        if (tx !== frame[b] || irq !== exp_irq) begin
          miscompares++;
          $display("FAIL a5_bit%0d_clk%0d got tx %b irq %b want tx %b irq %b", b, c, tx, irq, frame[b], exp_irq);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic s;
    int t_last;
    bit seen;
    bus_write(BASE + 32'd8, 32'd4);
    // The first byte is popped one edge after it lands, so 18 writes are needed to overrun 16 entries.
    for (int i = 0; i < 18; i++) bus_write(BASE, 32'(i + 8'h30));
    t_last = w_cyc;
    bus_read(BASE + 32'd4, d, s);
    vectors++;
    if (d !== 32'h0000_00FD) begin miscompares++; $display("FAIL ovf_status got %h want 000000fd", d); end
    bus_write(BASE + 32'd4, 32'h0);
    bus_read(BASE + 32'd4, d, s);
    vectors++;
    if (d !== 32'h0000_00F5) begin miscompares++; $display("FAIL ovf_clear got %h want 000000f5", d); end
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen || (cyc - t_last) != 680) begin
      miscompares++; $display("FAIL drain_17_frames got irq %b after %0d clks want 1 after 680", seen, cyc - t_last);
    end
  endtask

  task automatic test_baud_zero();
    logic exp_tx, exp_irq;
    bus_write(BASE + 32'd8, 32'd0);
    bus_write(BASE, 32'h0000_0000);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_tx  = !(k >= 2 && k <= 10);
      exp_irq = (k >= 11);
      vectors++;
      if (tx !== exp_tx || irq !== exp_irq) begin
        miscompares++;
        $display("FAIL baud0_k%0d got tx %b irq %b want tx %b irq %b", k, tx, irq, exp_tx, exp_irq);
      end
    end
  endtask

`ifdef MMIO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] byte_v;
    logic exp_tx, exp_irq;
    byte_v = 8'h07;
    bus_write(BASE + 32'd8, 32'd0);
    bus_write(BASE, 32'(byte_v));
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 2)                exp_tx = 1'b0;
      else if (k >= 3 && k <= 10) exp_tx = byte_v[k-3];
      else                        exp_tx = 1'b1;
      exp_irq = (k >= 12);
      vectors++;
      if (tx !== exp_tx || irq !== exp_irq) begin
        miscompares++;
        $display("FAIL parity_k%0d got tx %b irq %b want tx %b irq %b", k, tx, irq, exp_tx, exp_irq);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int bad;
    bus_write(BASE + 32'd8, 32'd4);
    bus_write(BASE, 32'h0);
    bus_write(BASE, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    vectors++;
    if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_data_tx got %b want 0", tx); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("FAIL async_reset_tx got %b want 1", tx); end
    addr = BASE + 32'd4;
    #1;
    vectors++;
    if (data_out !== 32'h0000_0002 || irq !== 1'b1) begin
      miscompares++; $display("FAIL reset_flush got status %h irq %b want 00000002 irq 1", data_out, irq);
    end
    addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL no_frame_after_reset got %0d low clks want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_overflow();
    test_baud_zero();
`ifdef MMIO_UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
